// File: rtl/agc_loop_ctrl_pkg.sv
// Shared types and helpers for the AGC loop controller and its gain integrator.
package agc_loop_ctrl_pkg;

  localparam int GW = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_HANG   = 2'd2,
    ST_DECAY  = 2'd3
  } agc_state_e;

  // Attack step: -((e << 7) >>> sh). The caller only uses it for e > 0.
  function automatic logic signed [GW-1:0] attack_step(input logic signed [16:0] e,
                                                        input logic [3:0] sh);
    logic signed [GW-1:0] ext;
    ext = GW'(e);
    ext = ext <<< 7;
    ext = ext >>> sh;
    return -ext;
  endfunction

endpackage

// File: rtl/agc_gain_int.sv
// Saturating 24-bit unsigned gain integrator with a programmable upper-byte ceiling.
module agc_gain_int
  import agc_loop_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic signed [GW-1:0] d_i,
  input  logic [7:0]           max_i,
  input  logic                 ld_i,
  input  logic [GW-1:0]        ld_val_i,
  output logic [GW-1:0]        gain_o,
  output logic                 gain_v_o
);

  logic [GW-1:0]        gain_q, gain_d;
  logic                 gain_v_q;
  logic signed [GW+1:0] sum;
  logic [GW-1:0]        ceil;

  // Two guard bits: gain up to 2^24-1 plus a positive step must not look negative.
  always_comb begin
    ceil = {max_i, 16'hFFFF};
    sum  = $signed({2'b00, gain_q}) + $signed({{2{d_i[GW-1]}}, d_i});
    if (sum[GW+1])
      gain_d = '0;
    else if (sum[GW] || (sum[GW-1:16] > max_i))
      gain_d = ceil;
    else
      gain_d = sum[GW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gain_q   <= '0;
      gain_v_q <= 1'b0;
    end else if (ld_i) begin
      gain_q   <= ld_val_i;
      gain_v_q <= 1'b0;
    end else if (ce_i) begin
      gain_q   <= gain_d;
      gain_v_q <= 1'b1;
    end else begin
      gain_v_q <= 1'b0;
    end
  end

  assign gain_o   = gain_q;
  assign gain_v_o = gain_v_q;

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop controller: stage 1 classifies each sample into attack/hang/decay, stage 2 integrates.
module agc_loop_ctrl
  import agc_loop_ctrl_pkg::*;
#(
  parameter int MW = 16,
  parameter int HW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [MW-1:0] mag_i,
  input  logic          mag_v_i,
  input  logic [MW-1:0] ref_i,
  input  logic [3:0]    atk_i,
  input  logic [15:0]   dstep_i,
  input  logic [HW-1:0] hang_i,
  input  logic [7:0]    max_i,
  input  logic          ld_i,
  input  logic [GW-1:0] ld_val_i,
  output logic [GW-1:0] gain_o,
  output logic          gain_v_o,
  output logic [1:0]    state_o,
  output logic          ovl_o
);

  logic signed [MW:0]   e_c, e_q;
  logic signed [16:0]   e_ext;
  agc_state_e           ph_c, ph_q, state_q;
  logic [HW-1:0]        hang_q, hang_d;
  logic                 s1_vld_q, ovl_q, accept, ce;
  logic signed [GW-1:0] d;

  assign accept = mag_v_i & en_i;

  always_comb begin
    e_c    = $signed({1'b0, mag_i}) - $signed({1'b0, ref_i});
    ph_c   = ST_DECAY;
    hang_d = hang_q;
    if (!e_c[MW] && (e_c != '0)) begin
      ph_c = ST_ATTACK;
      if (accept) hang_d = hang_i;
    end else if (hang_q != '0) begin
      ph_c = ST_HANG;
      if (accept) hang_d = hang_q - 1'b1;
    end
    if (!en_i) hang_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q      <= '0;
      ph_q     <= ST_IDLE;
      state_q  <= ST_IDLE;
      hang_q   <= '0;
      s1_vld_q <= 1'b0;
      ovl_q    <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      hang_q   <= hang_d;
      if (accept) begin
        e_q     <= e_c;
        ph_q    <= ph_c;
        state_q <= ph_c;
        ovl_q   <= (ph_c == ST_ATTACK);
      end else if (!en_i) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Stage 2 step; dropping en discards whatever sits in stage 1.
  always_comb begin
    e_ext = 17'(e_q);
    unique case (ph_q)
      ST_ATTACK: d = attack_step(e_ext, atk_i);
      ST_DECAY:  d = $signed({8'h00, dstep_i});
      default:   d = '0;
    endcase
  end

  assign ce = s1_vld_q & en_i;

  agc_gain_int u_int (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ce_i     (ce),
    .d_i      (d),
    .max_i    (max_i),
    .ld_i     (ld_i),
    .ld_val_i (ld_val_i),
    .gain_o   (gain_o),
    .gain_v_o (gain_v_o)
  );

  assign state_o = state_q;
  assign ovl_o   = ovl_q;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Scoreboard bench for agc_loop_ctrl: expected gains queued at drive time, checked on gain_v.
module tb_agc_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, mag_v, ld;
  logic [15:0] mag, ref_r, dstep;
  logic [3:0]  atk;
  logic [11:0] hang;
  logic [7:0]  maxv;
  logic [23:0] ld_val, gain;
  logic        gain_v, ovl;
  logic [1:0]  state;

  int          n_chk = 0, n_err = 0;
  int          gain_m = 0, hang_m = 0;
  logic [23:0] exp_q[$];

  agc_loop_ctrl #(.MW(16), .HW(12)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mag_i(mag), .mag_v_i(mag_v),
    .ref_i(ref_r), .atk_i(atk), .dstep_i(dstep), .hang_i(hang), .max_i(maxv),
    .ld_i(ld), .ld_val_i(ld_val), .gain_o(gain), .gain_v_o(gain_v),
    .state_o(state), .ovl_o(ovl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives one sample, models it, returns at the next negedge.
  task automatic send(input int m, input bit upd);
    int e, d, s;
    logic [1:0] ph;
    mag = 16'(m); mag_v = 1'b1;
    e = m - int'(ref_r);
    if (e > 0) begin
      ph = 2'd1; d = -((e * 128) >>> atk); hang_m = int'(hang);
    end else if (hang_m != 0) begin
      ph = 2'd2; d = 0; hang_m--;
    end else begin
      ph = 2'd3; d = int'(dstep);
    end
    if (upd) begin
      s = gain_m + d;
      if (s < 0) s = 0;
      else if ((s >> 16) > int'(maxv)) s = int'({maxv, 16'hFFFF});
      gain_m = s;
      exp_q.push_back(24'(s));
    end
    @(negedge clk);
    chk("state", {30'd0, state}, {30'd0, ph});
    chk("ovl", {31'd0, ovl}, {31'd0, (ph == 2'd1)});
  endtask

  task automatic idle();
    mag_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [23:0] v);
    ld = 1'b1; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
    gain_m = int'(v);
    chk("ld_gain", {8'd0, gain}, {8'd0, v});
    chk("ld_gv", {31'd0, gain_v}, 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (gain_v) begin
        if (exp_q.size() == 0) chk("gv_spurious", {31'd0, gain_v}, 32'd0);
        else chk("gain", {8'd0, gain}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; mag_v = 1'b0; ld = 1'b0; mag = '0; ref_r = 16'd1000;
    atk = 4'd4; dstep = 16'h0100; hang = 12'd3; maxv = 8'hFF; ld_val = '0;
    // reset with sample strobes toggling
    @(negedge clk);
    repeat (2) begin
      mag_v = ~mag_v;
      @(negedge clk);
    end
    chk("rst_gain", {8'd0, gain}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_ovl", {31'd0, ovl}, 32'd0);
    chk("rst_gv", {31'd0, gain_v}, 32'd0);
    mag_v = 1'b0; rst = 1'b0;
    @(negedge clk);

    // first sample latency: gain_v exactly two edges after drive
    send(500, 1'b1);
    chk("lat_n1", {31'd0, gain_v}, 32'd0);
    idle();
    chk("lat_n2", {31'd0, gain_v}, 32'd1);
    chk("first_gain", {8'd0, gain}, 32'h000100);

    // attack
    load(24'h100000);
    send(1064, 1'b1);
    idle();
    chk("atk_gain", {8'd0, gain}, 32'h0FFE00);

    // hang x3 then decay x2, back-to-back
    repeat (5) send(500, 1'b1);
    idle();
    chk("hang_decay_gain", {8'd0, gain}, 32'h100000);

    // ceiling, then lowered ceiling
    maxv = 8'h10;
    load(24'h10FF80);
    send(500, 1'b1);
    idle();
    chk("ceil1", {8'd0, gain}, 32'h10FFFF);
    maxv = 8'h08;
    send(500, 1'b1);
    idle();
    chk("ceil2", {8'd0, gain}, 32'h08FFFF);

    // floor
    maxv = 8'hFF; atk = 4'd0;
    load(24'h000010);
    send(1001, 1'b1);
    idle();
    chk("floor", {8'd0, gain}, 32'h0);

    // en drops while a sample is in stage 1
    load(24'h200000);
    send(1064, 1'b0);
    en = 1'b0;
    idle();
    hang_m = 0;
    chk("en_state", {30'd0, state}, 32'd0);
    chk("en_gain", {8'd0, gain}, 32'h200000);
    chk("en_gv", {31'd0, gain_v}, 32'd0);
    en = 1'b1;
    @(negedge clk);

    // ld coincident with a stage-2 update
    send(500, 1'b0);
    ld = 1'b1; ld_val = 24'h123456;
    idle();
    ld = 1'b0; gain_m = 32'h123456;
    chk("ldrace_gain", {8'd0, gain}, 32'h123456);
    chk("ldrace_gv", {31'd0, gain_v}, 32'd0);

    // e=0 never attacks; hang=0 goes straight from attack to decay
    hang = 12'd0; atk = 4'd3;
    send(1000, 1'b1);
    send(1100, 1'b1);
    send(900, 1'b1);
    idle();

    // random back-to-back traffic
    hang = 12'd2; atk = 4'd6;
    repeat (24) send(int'($urandom_range(0, 2000)), 1'b1);
    idle();
    idle();
    chk("q_empty", exp_q.size(), 32'd0);
    chk("final_gain", {8'd0, gain}, gain_m);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
